bfu_pipe_param: RTL and testbench

- Parametrised, fully pipelined modular butterfly unit. Successor to the fixed 16-bit Kyber butterfly.
- Adds:
  - generic modulus and width;
  - valid/ready handshake with backpressure;
  - per-beat mode capture;
  - a tag sideband;
  - a pointwise-multiply mode.
- Sits between the NTT address/twiddle sequencer and the coefficient RAM write-back path.

---
 rtl/bfu_pipe_param_if.sv | 29 ++
 rtl/bfu_pipe_param.sv | 183 ++++++++++++++++++
 tb/tb_bfu_pipe_param.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bfu_pipe_param_if.sv
// Valid/ready bundle for bfu_pipe_param: the input beat (mode, operands, tag)
// and the result beat. The master modport is the driving side, the slave is the unit.
interface bfu_pipe_param_if #(
    parameter int W     = 12,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_mode;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [W-1:0]     in_w;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_c;
    logic [W-1:0]     out_d;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_mode, in_a, in_b, in_w, in_tag, out_ready,
        input  in_ready, out_valid, out_c, out_d, out_tag
    );

    modport slave (
        input  in_valid, in_mode, in_a, in_b, in_w, in_tag, out_ready,
        output in_ready, out_valid, out_c, out_d, out_tag
    );
endinterface

// File: rtl/bfu_pipe_param.sv
// Four-stage modular butterfly (NTT/INTT/bypass/pointwise) with Barrett reduction.
// Defining BFU_HALVE_EN scales both INTT results by 2^-1 mod Q.
module bfu_pipe_param #(
    parameter int W     = 12,
    parameter int Q     = 3329,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    bfu_pipe_param_if.slave  bus,
    output logic             busy
);
    typedef enum logic [1:0] {
        MODE_NTT  = 2'b00,
        MODE_INTT = 2'b01,
        MODE_BYP  = 2'b10,
        MODE_PW   = 2'b11
    } mode_t;

    localparam logic [W:0]     Q1      = (W+1)'(Q);
    localparam logic [2*W:0]   MU_FULL = {1'b1, {(2*W){1'b0}}} / (2*W+1)'(Q);
    localparam logic [2*W-1:0] MU      = MU_FULL[2*W-1:0];

    if ((Q % 2) == 0 || Q <= 2 || Q >= (1 << W)) begin : g_q_check
        $error("bfu_pipe_param: Q must be odd with 2 < Q < 2**W");
    end

    logic             s1_valid, s2_valid, s3_valid, s4_valid;
    mode_t            s1_mode, s2_mode, s3_mode;
    logic [TAG_W-1:0] s1_tag, s2_tag, s3_tag, s4_tag;
    logic [W-1:0]     s1_a, s1_x1, s1_x2, s1_w;
    logic [W-1:0]     s2_a;
    logic [2*W-1:0]   s2_p1, s2_p2;
    logic [W-1:0]     s3_a;
    logic [W:0]       s3_r1, s3_r2;
    logic [W-1:0]     s4_c, s4_d;

    logic             adv;
    mode_t            in_mode;
    logic [W:0]       sum_ab;
    logic [W-1:0]     sum_mod, diff_mod;
    logic [W-1:0]     s1_a_n, s1_x1_n, s1_x2_n, s1_w_n;
    logic [2*W-1:0]   p1_n, p2_n;
    logic [4*W-1:0]   bq1_prod, bq2_prod;
    logic [W:0]       r1_n, r2_n;
    logic [W-1:0]     t1, t2, ntt_c, ntt_d, c_n, d_n;
    logic [W:0]       ntt_sum;
    logic             unused_bits;

    assign adv          = !s4_valid || bus.out_ready;
    assign bus.in_ready = adv;
    assign busy         = s1_valid || s2_valid || s3_valid || s4_valid;

    assign bus.out_valid = s4_valid;
    assign bus.out_c     = s4_c;
    assign bus.out_d     = s4_d;
    assign bus.out_tag   = s4_tag;

    // Stage 1: INTT pre-add/sub, and steer operands onto the two multiplier lanes.
    assign in_mode  = mode_t'(bus.in_mode);
    assign sum_ab   = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    assign sum_mod  = (sum_ab >= Q1) ? W'(sum_ab - Q1) : W'(sum_ab);
    assign diff_mod = (bus.in_b >= bus.in_a) ? (bus.in_b - bus.in_a)
                                             : W'({1'b0, bus.in_b} + Q1 - {1'b0, bus.in_a});

    always_comb begin
        s1_a_n  = bus.in_a;
        s1_x1_n = bus.in_b;
        s1_x2_n = bus.in_b;
        s1_w_n  = bus.in_w;
        case (in_mode)
            MODE_INTT: begin
                s1_a_n  = sum_mod;
                s1_x1_n = diff_mod;
            end
            MODE_BYP: begin
                s1_x1_n = bus.in_a;
                s1_w_n  = W'(1);
            end
            MODE_PW:  s1_x1_n = bus.in_a;
            default: ;
        endcase
    end

    assign p1_n = (2*W)'(s1_x1) * (2*W)'(s1_w);
    assign p2_n = (2*W)'(s1_x2) * (2*W)'(s1_w);

    // Barrett: the quotient estimate is at most one low, so p - qe*Q < 2Q fits in W+1 bits
    // and only the low W+1 bits of the subtraction are needed.
    assign bq1_prod = (4*W)'(s2_p1) * (4*W)'(MU);
    assign bq2_prod = (4*W)'(s2_p2) * (4*W)'(MU);
    assign r1_n     = s2_p1[W:0] - (bq1_prod[2*W +: W+1] * Q1);
    assign r2_n     = s2_p2[W:0] - (bq2_prod[2*W +: W+1] * Q1);
    assign unused_bits = ^{bq1_prod[2*W-1:0], bq1_prod[4*W-1:3*W+1],
                           bq2_prod[2*W-1:0], bq2_prod[4*W-1:3*W+1]};

`ifdef BFU_HALVE_EN
    function automatic logic [W-1:0] halve(input logic [W-1:0] x);
        return x[0] ? W'(({1'b0, x} + Q1) >> 1) : (x >> 1);
    endfunction
`endif

    always_comb begin
        t1      = (s3_r1 >= Q1) ? W'(s3_r1 - Q1) : W'(s3_r1);
        t2      = (s3_r2 >= Q1) ? W'(s3_r2 - Q1) : W'(s3_r2);
        ntt_sum = {1'b0, s3_a} + {1'b0, t1};
        ntt_c   = (ntt_sum >= Q1) ? W'(ntt_sum - Q1) : W'(ntt_sum);
        ntt_d   = (s3_a >= t1) ? (s3_a - t1) : W'({1'b0, s3_a} + Q1 - {1'b0, t1});
        c_n     = t1;
        d_n     = t2;
        case (s3_mode)
            MODE_NTT: begin
                c_n = ntt_c;
                d_n = ntt_d;
            end
            MODE_INTT: begin
`ifdef BFU_HALVE_EN
                c_n = halve(s3_a);
                d_n = halve(t1);
`else
                c_n = s3_a;
                d_n = t1;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s4_valid <= 1'b0;
            s1_mode  <= MODE_NTT;
            s2_mode  <= MODE_NTT;
            s3_mode  <= MODE_NTT;
            s1_tag   <= '0;
            s2_tag   <= '0;
            s3_tag   <= '0;
            s4_tag   <= '0;
            s1_a     <= '0;
            s1_x1    <= '0;
            s1_x2    <= '0;
            s1_w     <= '0;
            s2_a     <= '0;
            s2_p1    <= '0;
            s2_p2    <= '0;
            s3_a     <= '0;
            s3_r1    <= '0;
            s3_r2    <= '0;
            s4_c     <= '0;
            s4_d     <= '0;
        end else if (adv) begin
            s1_valid <= bus.in_valid;
            s1_mode  <= in_mode;
            s1_tag   <= bus.in_tag;
            s1_a     <= s1_a_n;
            s1_x1    <= s1_x1_n;
            s1_x2    <= s1_x2_n;
            s1_w     <= s1_w_n;

            s2_valid <= s1_valid;
            s2_mode  <= s1_mode;
            s2_tag   <= s1_tag;
            s2_a     <= s1_a;
            s2_p1    <= p1_n;
            s2_p2    <= p2_n;

            s3_valid <= s2_valid;
            s3_mode  <= s2_mode;
            s3_tag   <= s2_tag;
            s3_a     <= s2_a;
            s3_r1    <= r1_n;
            s3_r2    <= r2_n;

            s4_valid <= s3_valid;
            s4_tag   <= s3_tag;
            s4_c     <= c_n;
            s4_d     <= d_n;
        end
    end
endmodule

// File: tb/tb_bfu_pipe_param.sv
// Self-checking bench for bfu_pipe_param: directed vectors, backpressure, mid-flight
// reset and a randomized scoreboard run. Honours BFU_HALVE_EN when defined.
module tb_bfu_pipe_param;
    localparam int W     = 12;
    localparam int Q     = 3329;
    localparam int TAG_W = 8;
    localparam longint INV2 = (Q + 1) / 2;

    typedef struct {
        logic [W-1:0]     c;
        logic [W-1:0]     d;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    bfu_pipe_param_if #(.W(W), .TAG_W(TAG_W)) bus ();

    bfu_pipe_param #(.W(W), .Q(Q), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_mis = 0;
    int   n_in  = 0;
    int   n_out = 0;
    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: straight modular arithmetic on wide integers.
    function automatic exp_t ref_calc(input logic [1:0] m, input logic [W-1:0] a, b, w,
                                      input logic [TAG_W-1:0] tg);
        exp_t   r;
        longint la = longint'(a);
        longint lb = longint'(b);
        longint lw = longint'(w);
        longint lc, ld, t;
        case (m)
            2'd0: begin
                t  = (lb * lw) % Q;
                lc = (la + t) % Q;
                ld = (la - t + Q) % Q;
            end
            2'd1: begin
                lc = (la + lb) % Q;
                ld = (((lb - la + Q) % Q) * lw) % Q;
`ifdef BFU_HALVE_EN
                lc = (lc * INV2) % Q;
                ld = (ld * INV2) % Q;
`endif
            end
            2'd2: begin
                lc = la;
                ld = lb;
            end
            default: begin
                lc = (la * lw) % Q;
                ld = (lb * lw) % Q;
            end
        endcase
        r.c   = W'(lc);
        r.d   = W'(ld);
        r.tag = tg;
        return r;
    endfunction

    // One cycle starting at a negedge: drive, check any presented beat, book-keep, advance.
    task automatic cycle_io(input bit v, input logic [1:0] m, input logic [W-1:0] a, b, w,
                            input logic [TAG_W-1:0] tg, input bit ordy, output bit acc);
        exp_t e;
        bus.in_valid  = v;
        bus.in_mode   = m;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_w      = w;
        bus.in_tag    = tg;
        bus.out_ready = ordy;
        #1;
        acc = v && bus.in_ready;
        if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                chk("extra_beat", 64'd1, 64'd0);
            end else begin
                e = exp_q[0];
                chk("beat_c", 64'(bus.out_c), 64'(e.c));
                chk("beat_d", 64'(bus.out_d), 64'(e.d));
                chk("beat_tag", 64'(bus.out_tag), 64'(e.tag));
                if (ordy) begin
                    void'(exp_q.pop_front());
                    n_out++;
                end
            end
        end
        if (acc) begin
            exp_q.push_back(ref_calc(m, a, b, w, tg));
            n_in++;
        end
        @(negedge clk);
    endtask

    task automatic single(input string nm, input logic [1:0] m, input int a, b, w, tg, ec, ed);
        int lat;
        bus.in_valid  = 1'b1;
        bus.in_mode   = m;
        bus.in_a      = W'(a);
        bus.in_b      = W'(b);
        bus.in_w      = W'(w);
        bus.in_tag    = TAG_W'(tg);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'd4);
        chk({nm, "_c"}, 64'(bus.out_c), 64'(ec));
        chk({nm, "_d"}, 64'(bus.out_d), 64'(ed));
        chk({nm, "_tag"}, 64'(bus.out_tag), 64'(tg));
        repeat (2) @(negedge clk);
    endtask

    logic [W-1:0]     bp_a[8], bp_b[8], bp_w[8];
    bit               acc;
    int               nacc;
    int               cyc;
    int               out_base;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_mode   = 2'd0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_w      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_c", 64'(bus.out_c), 64'd0);
        chk("rst_out_d", 64'(bus.out_d), 64'd0);
        chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);

        single("ntt_basic", 2'd0, 1, 2, 17, 8'h5a, 35, 3296);
`ifdef BFU_HALVE_EN
        single("intt_basic", 2'd1, 5, 3, 17, 8'h11, 4, 3312);
`else
        single("intt_basic", 2'd1, 5, 3, 17, 8'h11, 8, 3295);
`endif
        single("ntt_wrap", 2'd0, 3328, 3328, 3328, 8'hc3, 0, 3327);
        single("pw_wrap", 2'd3, 3000, 1, 2, 8'h7e, 2671, 2);
        single("bypass", 2'd2, 1234, 3000, 99, 8'h01, 1234, 3000);

        // Backpressure: 8 beats offered back-to-back, downstream stalls from cycle 2.
        for (int i = 0; i < 8; i++) begin
            bp_a[i] = W'($urandom_range(0, Q - 1));
            bp_b[i] = W'($urandom_range(0, Q - 1));
            bp_w[i] = W'($urandom_range(0, Q - 1));
        end
        nacc     = 0;
        out_base = n_out;
        for (int c = 0; c < 12; c++) begin
            cycle_io(nacc < 8, 2'(nacc % 4), bp_a[nacc % 8], bp_b[nacc % 8], bp_w[nacc % 8],
                     TAG_W'(nacc), c < 2, acc);
            if (acc) nacc++;
        end
        chk("bp_held", 64'(nacc), 64'd4);
        chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        chk("bp_busy", 64'(busy), 64'd1);
        cyc = 0;
        while ((nacc < 8 || exp_q.size() > 0) && cyc < 40) begin
            cycle_io(nacc < 8, 2'(nacc % 4), bp_a[nacc % 8], bp_b[nacc % 8], bp_w[nacc % 8],
                     TAG_W'(nacc), 1'b1, acc);
            if (acc) nacc++;
            cyc++;
        end
        chk("bp_all_out", 64'(n_out - out_base), 64'd8);
        chk("bp_busy_after", 64'(busy), 64'd0);

        // Reset with three beats in flight, the oldest already presented.
        for (int i = 0; i < 5; i++) begin
            cycle_io(i < 3, 2'(i), W'(100 + i), W'(200 + i), W'(7), TAG_W'(8'h40 + i), 1'b0, acc);
        end
        chk("mid_pre_valid", 64'(bus.out_valid), 64'd1);
        chk("mid_pre_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_out_c", 64'(bus.out_c), 64'd0);
        chk("mid_out_d", 64'(bus.out_d), 64'd0);
        chk("mid_out_tag", 64'(bus.out_tag), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            cycle_io(1'b0, 2'd0, '0, '0, '0, '0, 1'b1, acc);
        end

        // Randomized traffic against the scoreboard.
        n_in     = 0;
        n_out    = 0;
        cyc      = 0;
        while (n_in < 10000 && cyc < 60000) begin
            cycle_io($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                     W'($urandom_range(0, Q - 1)), W'($urandom_range(0, Q - 1)),
                     W'($urandom_range(0, Q - 1)), TAG_W'($urandom_range(0, 255)),
                     $urandom_range(0, 3) != 0, acc);
            cyc++;
        end
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 100) begin
            cycle_io(1'b0, 2'd0, '0, '0, '0, '0, 1'b1, acc);
            cyc++;
        end
        chk("rand_in_count", 64'(n_in), 64'd10000);
        chk("rand_out_count", 64'(n_out), 64'd10000);
        chk("rand_drained", 64'(exp_q.size()), 64'd0);
        chk("rand_busy_end", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
